axi_read_arbiter: RTL and testbench

- Shares one AXI-Lite read master port (address channel plus data channel) between N_REQ requester ports.
- Sits between the CPU/DMA-side read masters and the peripheral read interconnect.
- Round-robin arbitration with exactly one outstanding read at a time.
- The read response is routed back only to the requester that won the grant.

---
 rtl/axi_read_arbiter.sv | 118 +++++++++++
 tb/tb_axi_read_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI-Lite read master port between N_REQ
// requesters with round-robin arbitration and a single outstanding read.
// The read response is steered back only to the requester holding the grant.
module axi_read_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [N_REQ*ADDR_SIZE-1:0] req_ARADDR,
  input  logic [N_REQ-1:0]           req_ARVALID,
  output logic [N_REQ-1:0]           req_ARREADY,
  output logic [DATA_BYTES*8-1:0]    req_RDATA,
  output logic [1:0]                 req_RRESP,
  output logic [N_REQ-1:0]           req_RVALID,
  input  logic [N_REQ-1:0]           req_RREADY,
  output logic [ADDR_SIZE-1:0]       ARADDR,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [DATA_BYTES*8-1:0]    RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RVALID,
  output logic                       RREADY
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;

  // Round-robin winner: first valid requester after the last completed grant.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!win_valid && req_ARVALID[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State, grant, last-grant and captured address registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; last-grant moves only when a read completes.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          addr_d  = req_ARADDR[int'(win_idx)*ADDR_SIZE +: ADDR_SIZE];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (RVALID && req_RREADY[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared master-side outputs; read data and response are pure pass-through.
  always_comb begin
    ARVALID   = (state_q == ADDR);
    ARADDR    = addr_q;
    RREADY    = (state_q == DATA) && req_RREADY[grant_q];
    req_RDATA = RDATA;
    req_RRESP = RRESP;
  end

  // Per-requester handshake outputs: only the winner / grant holder sees a 1.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_ARREADY[gi] = (state_q == IDLE) && win_valid && (win_idx == IDX_W'(gi));
      assign req_RVALID[gi]  = (state_q == DATA) && RVALID && (grant_q == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed table, hand-written corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_axi_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            srst;
  logic [N*AW-1:0] req_araddr;
  logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
  logic [DW-1:0]   req_rdata, rdata;
  logic [1:0]      req_rresp, rresp;
  logic [AW-1:0]   araddr;
  logic            arvalid, arready, rvalid, rready;

  axi_read_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .DATA_BYTES(DW/8)) dut (
    .ACLK        (clk),
    .ARESET      (srst),
    .req_ARADDR  (req_araddr),
    .req_ARVALID (req_arvalid),
    .req_ARREADY (req_arready),
    .req_RDATA   (req_rdata),
    .req_RRESP   (req_rresp),
    .req_RVALID  (req_rvalid),
    .req_RREADY  (req_rready),
    .ARADDR      (araddr),
    .ARVALID     (arvalid),
    .ARREADY     (arready),
    .RDATA       (rdata),
    .RRESP       (rresp),
    .RVALID      (rvalid),
    .RREADY      (rready)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy;
  int            m_owner;
  logic [AW-1:0] m_addr;
  bit            m_addr_sent;
  int            m_last = N - 1;
  int            done_order[$];
  bit            slv_pending;

  logic [N-1:0]  last_arready;
  logic          last_arvalid, last_rready;
  logic [AW-1:0] last_araddr;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] lane(input int w);
    return req_araddr[w*AW +: AW];
  endfunction

  task automatic set_lanes(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    for (int i = 0; i < N; i++) req_araddr[i*AW +: AW] = base + stride * AW'(i);
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    logic [N-1:0] exp_arready, exp_rvalid;
    logic         exp_arvalid, exp_rready;
    logic         obs_arvalid, obs_rready;
    int           w;
    #1;
    w           = rr_pick(req_arvalid, m_last);
    exp_arready = '0;
    exp_rvalid  = '0;
    exp_arvalid = 1'b0;
    exp_rready  = 1'b0;
    if (!m_busy) begin
      if (w >= 0) exp_arready = N'(1) << w;
    end else if (!m_addr_sent) begin
      exp_arvalid = 1'b1;
    end else begin
      exp_rready = req_rready[2'(m_owner)];
      exp_rvalid = rvalid ? (N'(1) << m_owner) : '0;
    end
    if (!srst) begin
      chk("ctl", 64'({req_arready, arvalid, rready, req_rvalid}),
          64'({exp_arready, exp_arvalid, exp_rready, exp_rvalid}));
      if (exp_arvalid) chk("araddr", 64'(araddr), 64'(m_addr));
      if (m_busy && m_addr_sent) chk("rpass", 64'({req_rdata, req_rresp}), 64'({rdata, rresp}));
    end
    last_arready = req_arready;
    last_arvalid = arvalid;
    last_rready  = rready;
    last_araddr  = araddr;
    obs_arvalid  = arvalid;
    obs_rready   = rready;
    @(posedge clk);
    if (srst) begin
      m_busy      = 0;
      m_addr_sent = 0;
      m_last      = N - 1;
      slv_pending = 0;
    end else begin
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy      = 1;
          m_owner     = w;
          m_addr      = lane(w);
          m_addr_sent = 0;
        end
      end else if (!m_addr_sent) begin
        if (arready) m_addr_sent = 1;
      end else if (rvalid && req_rready[2'(m_owner)]) begin
        done_order.push_back(m_owner);
        m_last = m_owner;
        m_busy = 0;
      end
      if (obs_arvalid && arready) slv_pending = 1;
      else if (rvalid && obs_rready) slv_pending = 0;
    end
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]  arv;
    logic          ary;
    logic          rv;
    logic [DW-1:0] rd;
    logic [1:0]    rr;
    logic [N-1:0]  rdy;
    logic [N-1:0]  e_ary;
    logic          e_av;
    logic [AW-1:0] e_addr;
    logic          e_rr;
    logic [N-1:0]  e_rv;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [N-1:0] arv, input logic ary, input logic rv,
                              input logic [DW-1:0] rd, input logic [1:0] rr,
                              input logic [N-1:0] rdy, input logic [N-1:0] e_ary,
                              input logic e_av, input logic [AW-1:0] e_addr,
                              input logic e_rr, input logic [N-1:0] e_rv);
    vec_t v;
    v.arv = arv; v.ary = ary; v.rv = rv; v.rd = rd; v.rr = rr; v.rdy = rdy;
    v.e_ary = e_ary; v.e_av = e_av; v.e_addr = e_addr; v.e_rr = e_rr; v.e_rv = e_rv;
    return v;
  endfunction

  initial begin
    int cyc, n0, av_cycles, hold_cycles;

    // lanes: req0=0x0E00, req1=0x0F00, req2=0x1000, req3=0x1100
    tbl[0]  = mk(4'b0000, 1, 0, 32'h0,        2'b00, 4'b0000, 4'b0000, 0, 32'h0,    0, 4'b0000);
    tbl[1]  = mk(4'b0100, 1, 0, 32'h0,        2'b00, 4'b0100, 4'b0100, 0, 32'h0,    0, 4'b0000);
    tbl[2]  = mk(4'b0000, 1, 1, 32'hAAAA5555, 2'b01, 4'b0100, 4'b0000, 1, 32'h1000, 0, 4'b0000);
    tbl[3]  = mk(4'b0000, 0, 1, 32'hDEADBEEF, 2'b00, 4'b0100, 4'b0000, 0, 32'h0,    1, 4'b0100);
    tbl[4]  = mk(4'b1001, 0, 0, 32'h0,        2'b00, 4'b0000, 4'b1000, 0, 32'h0,    0, 4'b0000);
    tbl[5]  = mk(4'b1001, 0, 0, 32'h0,        2'b00, 4'b0000, 4'b0000, 1, 32'h1100, 0, 4'b0000);
    tbl[6]  = mk(4'b1001, 1, 0, 32'h0,        2'b00, 4'b0000, 4'b0000, 1, 32'h1100, 0, 4'b0000);
    tbl[7]  = mk(4'b1001, 0, 1, 32'h12345678, 2'b10, 4'b1000, 4'b0000, 0, 32'h0,    1, 4'b1000);
    tbl[8]  = mk(4'b1001, 0, 0, 32'h0,        2'b00, 4'b0000, 4'b0001, 0, 32'h0,    0, 4'b0000);
    tbl[9]  = mk(4'b1001, 1, 0, 32'h0,        2'b00, 4'b0000, 4'b0000, 1, 32'h0E00, 0, 4'b0000);
    tbl[10] = mk(4'b1001, 0, 0, 32'h5A5A5A5A, 2'b11, 4'b0001, 4'b0000, 0, 32'h0,    1, 4'b0000);
    tbl[11] = mk(4'b1001, 0, 1, 32'h0BADF00D, 2'b00, 4'b0000, 4'b0000, 0, 32'h0,    0, 4'b0001);
    tbl[12] = mk(4'b1001, 0, 1, 32'h0BADF00D, 2'b00, 4'b0001, 4'b0000, 0, 32'h0,    1, 4'b0001);
    tbl[13] = mk(4'b0011, 0, 0, 32'h0,        2'b00, 4'b0000, 4'b0010, 0, 32'h0,    0, 4'b0000);

    srst = 1; req_arvalid = '0; req_araddr = '0; req_rready = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    @(negedge clk);
    step(); step();
    srst = 0;

    set_lanes(32'h0E00, 32'h100);
    for (int i = 0; i < 14; i++) begin
      req_arvalid = tbl[i].arv; arready = tbl[i].ary; rvalid = tbl[i].rv;
      rdata = tbl[i].rd; rresp = tbl[i].rr; req_rready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_ctl", i), 64'({req_arready, arvalid, rready, req_rvalid}),
          64'({tbl[i].e_ary, tbl[i].e_av, tbl[i].e_rr, tbl[i].e_rv}));
      if (tbl[i].e_av) chk($sformatf("tbl%0d_araddr", i), 64'(araddr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_rpass", i), 64'({req_rdata, req_rresp}), 64'({tbl[i].rd, tbl[i].rr}));
      @(posedge clk);
      @(negedge clk);
    end

    // Reset both DUT and model before the model-checked sequences.
    srst = 1; req_arvalid = '0; arready = 0; rvalid = 0; req_rready = '0;
    step(); step();
    srst = 0;

    // All four requesters valid continuously: 8 reads, 3 cycles each.
    set_lanes(32'h4000_0000, 32'h10);
    req_arvalid = 4'hF; arready = 1; rvalid = 1; req_rready = 4'hF;
    done_order.delete();
    cyc = 0;
    while (done_order.size() < 8 && cyc < 100) begin
      rdata = $urandom;
      step();
      cyc++;
    end
    chk("rr8_cycles", 64'(cyc), 64'(24));
    chk("rr8_count", 64'(done_order.size()), 64'(8));
    for (int i = 0; i < done_order.size() && i < 8; i++)
      chk($sformatf("rr8_order%0d", i), 64'(done_order[i]), 64'(i % 4));

    // Backpressure: ARREADY low 5 cycles, then RREADY low 3 cycles.
    n0 = done_order.size();
    req_arvalid = 4'b0001; arready = 0; rvalid = 0; req_rready = '0;
    step();
    req_arvalid = '0;
    av_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      arready = (i == 5);
      step();
      if (last_arvalid && last_araddr == 32'h4000_0000) av_cycles++;
    end
    chk("bp_arvalid_cycles", 64'(av_cycles), 64'(6));
    arready = 0; rvalid = 1; rdata = 32'hCAFE0001; rresp = 2'b00;
    hold_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!last_rready) hold_cycles++;
    end
    chk("bp_hold", 64'(hold_cycles), 64'(3));
    chk("bp_not_done", 64'(done_order.size()), 64'(n0));
    req_rready = 4'b0001;
    step();
    chk("bp_done", 64'(done_order.size()), 64'(n0 + 1));

    // After requester 1 completes, only 0 and 1 request: 0 then 1.
    req_arvalid = 4'b0010; arready = 1; rvalid = 1; req_rready = 4'hF;
    step(); step(); step();
    n0 = done_order.size();
    req_arvalid = 4'b0011;
    for (int i = 0; i < 6; i++) step();
    chk("wrap_count", 64'(done_order.size()), 64'(n0 + 2));
    if (done_order.size() >= n0 + 2) begin
      chk("wrap_first", 64'(done_order[n0]), 64'(0));
      chk("wrap_second", 64'(done_order[n0 + 1]), 64'(1));
    end

    // Reset while in DATA with RVALID high.
    req_arvalid = 4'b1000; arready = 1; rvalid = 1; req_rready = '0;
    step(); step(); step();
    srst = 1;
    step();
    srst = 0; req_arvalid = '0; rvalid = 0;
    step();
    chk("rst_idle", 64'({last_arready, last_arvalid, last_rready}), 64'(0));
    req_arvalid = 4'b1001;
    step();
    chk("rst_grant", 64'(last_arready), 64'(4'b0001));

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      srst        = ($urandom_range(0, 199) == 0);
      req_arvalid = 4'($urandom);
      for (int i = 0; i < N; i++) req_araddr[i*AW +: AW] = $urandom;
      arready     = ($urandom_range(0, 3) != 0);
      rvalid      = slv_pending && ($urandom_range(0, 2) != 0);
      rdata       = $urandom;
      rresp       = 2'($urandom);
      req_rready  = 4'($urandom);
      step();
    end
    srst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
